// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for RV64 DIV/REM[U][W]: N+2 cycles accept-to-result (N=64, or 32 for W ops), 1 cycle for divide-by-zero/overflow.
// One op in flight: in_ready only in IDLE; the result is held in DONE until out_ready; flush kills the op from any state.
module iter_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] dividend_ex,
   input  logic [XLEN-1:0] divisor_ex,
   input  logic [2:0]      div_op,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int HW = XLEN / 2;
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvd_q;      // dividend bits shift out at the top, quotient bits shift in at the bottom
   logic [XLEN-1:0] dsr_q;
   logic [XLEN-1:0] rem_q;
   logic            op_w_q, op_rem_q, neg_quo_q, neg_rem_q;

   logic            accept, is_w, is_uns, a_neg, b_neg, div_zero, sgn_ovf, special;
   logic [XLEN-1:0] a_sext_w, a_ext, b_ext, a_mag, b_mag, min_op, spec_res;
   logic [XLEN:0]   shifted, diff;
   logic [XLEN-1:0] sel_fix;

   // Operand conditioning and special-case detection on the request port
   always_comb begin
      is_w     = div_op[2];
      is_uns   = div_op[0];
      a_sext_w = {{HW{dividend_ex[HW-1]}}, dividend_ex[HW-1:0]};
      a_ext    = is_w ? (is_uns ? {{HW{1'b0}}, dividend_ex[HW-1:0]} : a_sext_w) : dividend_ex;
      b_ext    = is_w ? (is_uns ? {{HW{1'b0}}, divisor_ex[HW-1:0]}
                                : {{HW{divisor_ex[HW-1]}}, divisor_ex[HW-1:0]}) : divisor_ex;
      a_neg    = !is_uns && a_ext[XLEN-1];
      b_neg    = !is_uns && b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      min_op   = is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (b_ext == '0);
      sgn_ovf  = !is_uns && (b_ext == '1) && (a_ext == min_op);
      special  = div_zero || sgn_ovf;
      if (div_zero)
         spec_res = div_op[1] ? (is_w ? a_sext_w : dividend_ex) : '1;
      else
         spec_res = div_op[1] ? '0 : min_op;
   end

   assign accept = in_valid && in_ready && !flush;

   always_comb begin
      shifted = {rem_q, dvd_q[XLEN-1]};
      diff    = shifted - {1'b0, dsr_q};
      if (op_rem_q)
         sel_fix = neg_rem_q ? -rem_q : rem_q;
      else
         sel_fix = neg_quo_q ? -dvd_q : dvd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
         CALC:    if (cnt == '0) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush)
         state_nxt = IDLE;
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         op_w_q    <= 1'b0;
         op_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_w_q    <= is_w;
               op_rem_q  <= div_op[1];
               neg_quo_q <= a_neg ^ b_neg;
               neg_rem_q <= a_neg;
               dsr_q     <= b_mag;
               // W ops park the 32-bit magnitude at the top so the MSB-first loop sees it first
               dvd_q     <= is_w ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
               rem_q     <= '0;
               cnt       <= is_w ? CW'(HW - 1) : CW'(XLEN - 1);
               if (special)
                  result <= spec_res;
            end
            CALC: begin
               if (!diff[XLEN]) begin
                  rem_q <= diff[XLEN-1:0];
                  dvd_q <= {dvd_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[XLEN-1:0];
                  dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
            end
            FIX: result <= op_w_q ? {{HW{sel_fix[HW-1]}}, sel_fix[HW-1:0]} : sel_fix;
            default: ;
         endcase
      end
   end

endmodule
